// File: rtl/seq_run_tracker_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_run_tracker_if
// Brief    : Input beat stream and result stream of the run-length tracker.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_run_tracker_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 4
);
    logic [NCH-1:0]       in_data;
    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;
    logic [NCH*CNT_W-1:0] out_max;
    logic [NCH-1:0]       out_sat;
    logic                 out_valid;
    logic                 out_ready;

    // Upstream/downstream side of the block
    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_max, out_sat, out_valid
    );

    // The tracker itself
    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_max, out_sat, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/seq_run_tracker.sv
`default_nettype none
// ============================================================================
// Module   : seq_run_tracker
// Brief    : Per-channel longest-run-of-ones tracker with saturating counts,
//            framed by in_last, result held in a one-deep output register.
// Revision : 1.0 - initial release
// ============================================================================
module seq_run_tracker #(
    parameter int NCH   = 4,
    parameter int CNT_W = 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    seq_run_tracker_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [NCH-1:0][CNT_W-1:0] cur_q, cur_d;
    logic [NCH-1:0][CNT_W-1:0] max_q, max_d;
    logic [NCH-1:0]            sat_q, sat_d;
    logic [NCH-1:0][CNT_W-1:0] out_max_q, out_max_d;
    logic [NCH-1:0]            out_sat_q, out_sat_d;
    logic                      out_valid_q, out_valid_d;

    logic [NCH-1:0][CNT_W-1:0] nxt_w;
    logic [NCH-1:0][CNT_W-1:0] mx_w;
    logic [NCH-1:0]            sf_w;
    logic [NCH-1:0]            full_w;
    logic                      ready_w;
    logic                      acc_w;

    // The output register is one deep, so a new beat may only enter when the
    // held result is absent or being taken this cycle.
    assign ready_w = !reset && (!out_valid_q || bus.out_ready);
    assign acc_w   = bus.in_valid && ready_w;

    assign bus.in_ready  = ready_w;
    assign bus.out_max   = out_max_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.out_valid = out_valid_q;

    // Per-channel candidate values assuming the current beat is accepted
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign full_w[c] = (cur_q[c] == CNT_MAX);
        assign nxt_w[c]  = bus.in_data[c] ? (full_w[c] ? CNT_MAX : cur_q[c] + CNT_ONE)
                                          : {CNT_W{1'b0}};
        // The maximum includes the run as updated by this beat
        assign mx_w[c]   = (nxt_w[c] > max_q[c]) ? nxt_w[c] : max_q[c];
        assign sf_w[c]   = sat_q[c] | (bus.in_data[c] & full_w[c]);
    end

    // Next-state: run update on accepted beats, result capture on last beat
    always_comb begin
        cur_d       = cur_q;
        max_d       = max_q;
        sat_d       = sat_q;
        out_max_d   = out_max_q;
        out_sat_d   = out_sat_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (acc_w) begin
            if (bus.in_last) begin
                // Publish the frame result and start the next frame clean;
                // this also covers consume-and-reload in the same cycle.
                out_max_d   = mx_w;
                out_sat_d   = sf_w;
                out_valid_d = 1'b1;
                cur_d       = '0;
                max_d       = '0;
                sat_d       = '0;
            end else begin
                cur_d = nxt_w;
                max_d = mx_w;
                sat_d = sf_w;
            end
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_q       <= '0;
            max_q       <= '0;
            sat_q       <= '0;
            out_max_q   <= '0;
            out_sat_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cur_q       <= cur_d;
            max_q       <= max_d;
            sat_q       <= sat_d;
            out_max_q   <= out_max_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_seq_run_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_run_tracker
// Brief    : Directed plus short random bench with a reference model and a
//            scoreboard of expected frame results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_run_tracker;
    localparam int NCH   = 4;
    localparam int CNT_W = 4;
    localparam int MAXV  = (1 << CNT_W) - 1;

    logic clk;
    logic reset;

    seq_run_tracker_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

    seq_run_tracker #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int                   cur_m [NCH];
    int                   max_m [NCH];
    bit                   sat_m [NCH];
    logic [NCH*CNT_W-1:0] omax_m;
    logic [NCH-1:0]       osat_m;
    bit                   ov_m;
    logic [NCH*CNT_W+NCH-1:0] sb [$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, check outputs,
    // advance the model through the coming rising edge.
    task automatic beat(input logic r, input logic v, input logic [NCH-1:0] d,
                        input logic l, input logic ordy);
        bit rdy, acc;
        int n, m, old;
        bit s;
        reset        = r;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_last  = l;
        bus.out_ready = ordy;
        #1;
        rdy = !r && (!ov_m || ordy);
        acc = v && rdy;
        chk("in_ready", {63'd0, bus.in_ready}, {63'd0, rdy});
        chk("out_valid", {63'd0, bus.out_valid}, {63'd0, ov_m});
        chk("out_max", 64'(bus.out_max), 64'(omax_m));
        chk("out_sat", 64'(bus.out_sat), 64'(osat_m));
        if (ov_m) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 64'd0, 64'd1);
            end else begin
                chk("sb_result", 64'({bus.out_max, bus.out_sat}), 64'(sb[0]));
                if (ordy) void'(sb.pop_front());
            end
        end
        if (r) begin
            for (int c = 0; c < NCH; c++) begin
                cur_m[c] = 0; max_m[c] = 0; sat_m[c] = 0;
            end
            omax_m = '0; osat_m = '0; ov_m = 0;
            sb.delete();
        end else begin
            if (ov_m && ordy) ov_m = 0;
            if (acc) begin
                for (int c = 0; c < NCH; c++) begin
                    old = cur_m[c];
                    n = d[c] ? ((old == MAXV) ? MAXV : old + 1) : 0;
                    m = (n > max_m[c]) ? n : max_m[c];
                    s = sat_m[c] || (d[c] && old == MAXV);
                    if (l) begin
                        omax_m[c*CNT_W +: CNT_W] = CNT_W'(m);
                        osat_m[c] = s;
                        cur_m[c] = 0; max_m[c] = 0; sat_m[c] = 0;
                    end else begin
                        cur_m[c] = n; max_m[c] = m; sat_m[c] = s;
                    end
                end
                if (l) begin
                    ov_m = 1;
                    sb.push_back({omax_m, osat_m});
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) begin
            cur_m[c] = 0; max_m[c] = 0; sat_m[c] = 0;
        end
        omax_m = '0; osat_m = '0; ov_m = 0;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset held with in_valid high
        beat(1, 1, 4'hF, 0, 1);
        beat(1, 1, 4'hF, 0, 1);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_out_max", 64'(bus.out_max), 64'd0);

        // Basic frame: ch0 1,1,1,0,1 ; ch1 all ones
        beat(0, 1, 4'b0011, 0, 1);
        beat(0, 1, 4'b0011, 0, 1);
        beat(0, 1, 4'b0011, 0, 1);
        beat(0, 1, 4'b0010, 0, 1);
        beat(0, 1, 4'b0011, 1, 1);
        chk("basic_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("basic_ch0", 64'(bus.out_max[3:0]), 64'd3);
        chk("basic_ch1", 64'(bus.out_max[7:4]), 64'd5);
        chk("basic_sat0", {63'd0, bus.out_sat[0]}, 64'd0);
        beat(0, 0, 4'b0000, 0, 1);

        // Saturation on ch2
        for (int i = 0; i < 20; i++) beat(0, 1, 4'b0100, 0, 1);
        beat(0, 1, 4'b0000, 1, 1);
        chk("sat_ch2_max", 64'(bus.out_max[11:8]), 64'd15);
        chk("sat_ch2_flag", {63'd0, bus.out_sat[2]}, 64'd1);
        beat(0, 1, 4'b0000, 1, 1);
        chk("after_sat_max", 64'(bus.out_max), 64'd0);
        chk("after_sat_flag", 64'(bus.out_sat), 64'd0);

        // Backpressure: held result blocks further beats
        beat(0, 1, 4'b0001, 1, 1);
        beat(0, 1, 4'b1111, 0, 0);
        beat(0, 1, 4'b1111, 0, 0);
        beat(0, 1, 4'b1111, 0, 0);
        chk("bp_hold_max", 64'(bus.out_max), 64'h0001);
        beat(0, 1, 4'b1111, 0, 1);
        chk("bp_consumed", {63'd0, bus.out_valid}, 64'd0);
        beat(0, 1, 4'b0000, 1, 1);
        chk("bp_next_max", 64'(bus.out_max), 64'h1111);

        // Back-to-back single-beat frames
        beat(0, 1, 4'b1010, 1, 1);
        chk("b2b_first", 64'(bus.out_max), 64'h1010);
        beat(0, 1, 4'b0101, 1, 1);
        chk("b2b_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("b2b_second", 64'(bus.out_max), 64'h0101);
        beat(0, 0, 4'b0000, 0, 1);

        // Reset in the middle of a frame
        beat(0, 1, 4'b0001, 0, 1);
        beat(0, 1, 4'b0001, 0, 1);
        beat(0, 1, 4'b0001, 0, 1);
        beat(1, 0, 4'b0000, 0, 1);
        beat(0, 1, 4'b0001, 1, 1);
        chk("midrst_ch0", 64'(bus.out_max[3:0]), 64'd1);

        // Random traffic with random output stalls
        for (int i = 0; i < 300; i++) begin
            beat(0, $urandom_range(0, 3) != 0, NCH'($urandom),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
        end
        repeat (3) beat(0, 0, 4'b0000, 0, 1);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/seq_run_tracker.md
# seq_run_tracker

Parametrised multi-channel run-length tracker. Each beat on a valid/ready input stream carries one bit per channel. For every channel the block tracks the current run of consecutive 1s and the longest run seen in the current frame. When the beat marked last is accepted, it emits the per-channel maxima and saturation flags as one result on a valid/ready output port, then clears its state for the next frame. It sits in the stream-statistics path and generalises the single-bit longest-run counter to NCH channels with saturating counts, framing and output backpressure.

## Interface
- NCH, default 4, number of independent channels (bits per input beat), ≥1
- CNT_W, default 4, run counter width; counts saturate at 2^CNT_W-1
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- in_data  input  NCH  bit c feeds channel c
- in_valid  input  1  input beat present
- in_last  input  1  beat closes the frame; qualified by in_valid
- in_ready  output  1  block can accept a beat this cycle
- out_max  output  NCH*CNT_W  per-channel longest run; channel c at [c*CNT_W +: CNT_W]
- out_sat  output  NCH  channel c saturated during the frame
- out_valid  output  1  result held on out_max/out_sat
- out_ready  input  1  downstream takes the result

## Operation
- Accept condition: acc = in_valid && in_ready.
- in_ready = !reset && (!out_valid || out_ready). This is combinational from out_ready, and the output register is one deep.
- Per-channel state: cur[c], max[c] (CNT_W bits) and sat[c] (1 bit).
- On acc, for each channel c:
  - nxt = in_data[c] ? (cur[c]==all-ones ? all-ones : cur[c]+1) : 0. Counts saturate and never wrap.
  - mx = (nxt > max[c]) ? nxt : max[c]. The comparison uses the post-update value, so the current beat counts toward the maximum.
  - sf = sat[c] || (in_data[c] && cur[c]==all-ones).
  - If !in_last: cur<=nxt, max<=mx, sat<=sf.
  - If in_last: out_max[c]<=mx, out_sat[c]<=sf, then cur, max and sat are all cleared to 0.
- With no acc, cur, max and sat hold.
- out_valid:
  - Set when a last beat is accepted.
  - Cleared on out_valid && out_ready when no last beat is accepted in the same cycle.
  - If a result is consumed and a new last beat is accepted in the same cycle, out_valid stays 1 and out_max/out_sat load the new values.
- out_max and out_sat change only when a last beat is accepted. They hold while out_valid=1 && out_ready=0.
- A frame may be a single beat (in_last on its first beat).
- No state machine beyond the out_valid flag. Frame state is implicit in cur, max and sat.

## Timing
- Reset, synchronous and active-high:
  - cur, max, sat, out_max and out_sat are 0; out_valid=0.
  - in_ready=0 while reset is high.
  - Reset mid-frame discards the partial frame. Reset while out_valid=1 drops the pending result.
- Latency: the result is visible on out_valid the cycle after the last beat is accepted (1 cycle).
- Throughput: 1 beat/cycle when out_ready is held high, including back-to-back last beats.
- Backpressure:
  - While out_valid=1 && out_ready=0, in_ready=0 and no beat is accepted. Non-last beats also stall, which keeps behaviour simple.
  - in_data, in_last and in_valid must be held stable by upstream until accepted. The block does not check this.
- Beats with in_valid=1 and in_ready=0 have no effect on state.

## Test plan
- Reset: assert reset for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_max=0, out_sat=0; first beat after deassertion is accepted.
- Basic run, NCH=4, CNT_W=4, out_ready=1: ch0 bits 1,1,1,0,1 with in_last on beat 5 -> next cycle out_valid=1, out_max[3:0]=3, out_sat[0]=0; ch1 all ones -> out_max[7:4]=5.
- Saturation: ch2 = 20 consecutive ones then last beat with bit 0 -> out_max[11:8]=15, out_sat[2]=1; the next frame starts with sat=0 and max=0.
- Backpressure: last beat accepted, out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0 for those cycles, out_max stable, no state change; out_ready=1 -> result consumed, beat accepted the same cycle.
- Back-to-back single-beat frames with out_ready=1: in_data=4'b1010 then 4'b0101, both with last -> out_valid stays 1 for 2 cycles, out_max shows 1,0,1,0 then 0,1,0,1 (per channel from ch3 down to ch0).
- Reset mid-frame: 3 ones on ch0, reset 1 cycle, then 1 one with last -> out_max[3:0]=1.
